// File: rtl/letter_sequencer_if.sv
// letter_sequencer_if
//   Groups the keystroke / text-ROM / status signals of letter_sequencer.
//   master : keyboard decoder + text ROM side (drives start, key, target)
//   slave  : letter_sequencer itself (drives index and status outputs)
//
// Handshake: there is no ready. key_valid is a one-cycle strobe qualifying
// key_code; start is a one-cycle pulse. The sequencer samples both on every
// rising clk edge and silently drops a keystroke whenever it is not in
// TYPING (IDLE, HOLD, DONE) or when start arrives in the same cycle.
// target_code must be a combinational function of letter_idx, valid in the
// same cycle.
//
// Signals:
//   start       master->slave  begin/restart a session
//   key_valid   master->slave  keystroke strobe
//   key_code    master->slave  ASCII of keystroke
//   target_code master->slave  ASCII of text character at letter_idx
//   letter_idx  slave->master  index of expected character
//   correct     slave->master  level, held per matched keystroke
//   wrong       slave->master  one-cycle pulse per mismatched keystroke
//   mistakes    slave->master  saturating mismatch count
//   active      slave->master  high while TYPING or HOLD
//   done        slave->master  high once the last character matched
//   state_dbg   slave->master  raw FSM state for debug/observation
interface letter_sequencer_if #(
    parameter int IDX_W = 6,
    parameter int ERR_W = 8
);
    logic             start;
    logic             key_valid;
    logic [7:0]       key_code;
    logic [7:0]       target_code;
    logic [IDX_W-1:0] letter_idx;
    logic             correct;
    logic             wrong;
    logic [ERR_W-1:0] mistakes;
    logic             active;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output start, key_valid, key_code, target_code,
        input  letter_idx, correct, wrong, mistakes, active, done, state_dbg
    );

    modport slave (
        input  start, key_valid, key_code, target_code,
        output letter_idx, correct, wrong, mistakes, active, done, state_dbg
    );
endinterface

// File: rtl/letter_sequencer.sv
// letter_sequencer
//   Compares each keystroke against the expected character of the practice
//   text. A match raises `correct` for HOLD_CYCLES cycles (a level that a
//   downstream edge detector turns into one advance pulse), then advances
//   letter_idx. A mismatch pulses `wrong` and bumps a saturating mistake
//   counter. After the last character matches, `done` is raised until the
//   next start or reset.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    letter_sequencer_if.slave (start, key_valid, key_code,
//          target_code in; letter_idx, correct, wrong, mistakes, active,
//          done, state_dbg out)
//
// All outputs come straight from registers.
module letter_sequencer #(
    parameter int TEXT_LEN    = 32,
    parameter int IDX_W       = 6,
    parameter int ERR_W       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter bit CASE_FOLD   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    letter_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TYPING = 2'd1,
        S_HOLD   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TEXT_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ERR_W-1:0]  mistakes_q, mistakes_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              correct_q, correct_d;
    logic              wrong_q, wrong_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              key_match;

    // Only lowercase ASCII letters are folded; every other code, including
    // the punctuation sitting next to the letter ranges, compares exactly.
    function automatic logic [7:0] fold(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (CASE_FOLD && (c >= 8'h61) && (c <= 8'h7A)) begin
            r = c - 8'h20;
        end
        return r;
    endfunction

    assign key_match = (fold(bus.key_code) == fold(bus.target_code));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mistakes_d = mistakes_q;
        hold_d     = hold_q;
        correct_d  = correct_q;
        wrong_d    = 1'b0;
        active_d   = active_q;
        done_d     = done_q;

        if (bus.start) begin
            // start wins in every state; a same-cycle keystroke is dropped.
            state_d    = S_TYPING;
            idx_d      = '0;
            mistakes_d = '0;
            hold_d     = '0;
            correct_d  = 1'b0;
            active_d   = 1'b1;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // keystrokes ignored until a session starts
                end

                S_TYPING: begin
                    if (bus.key_valid) begin
                        if (key_match) begin
                            state_d   = S_HOLD;
                            correct_d = 1'b1;
                            hold_d    = HOLD_LOAD;
                        end else begin
                            wrong_d = 1'b1;
                            if (mistakes_q != ERR_MAX) begin
                                mistakes_d = mistakes_q + ERR_ONE;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    // Keystrokes during HOLD are dropped. Leaving HOLD always
                    // clears correct for at least one cycle, so consecutive
                    // matches give distinct rising edges.
                    if (hold_q == '0) begin
                        correct_d = 1'b0;
                        if (idx_q < LAST_IDX) begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = S_TYPING;
                        end else begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            active_d = 1'b0;
                        end
                    end else begin
                        hold_d = hold_q - HOLD_ONE;
                    end
                end

                S_DONE: begin
                    // frozen until start
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            mistakes_q <= '0;
            hold_q     <= '0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mistakes_q <= mistakes_d;
            hold_q     <= hold_d;
            correct_q  <= correct_d;
            wrong_q    <= wrong_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign bus.letter_idx = idx_q;
    assign bus.correct    = correct_q;
    assign bus.wrong      = wrong_q;
    assign bus.mistakes   = mistakes_q;
    assign bus.active     = active_q;
    assign bus.done       = done_q;
    assign bus.state_dbg  = state_q;

endmodule
